// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration bitstream loader: preamble/start-code detection, 24-bit length
// capture, then NUM_FRAMES framed data words, each emitted with a one-cycle FRAME_VALID.
module xc20xx_cfg_loader #(
    parameter int FRAME_BITS = 46,
    parameter int NUM_FRAMES = 160,
    parameter int PRE_ONES   = 8
) (
    input  logic                  K,
    input  logic                  R,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [7:0]            FRAME_ADDR,
    output logic                  FRAME_VALID,
    output logic [23:0]           LENGTH,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_LEN,
        S_LTRAIL,
        S_FSTART,
        S_FDATA,
        S_FSTOP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] PRE_MAX  = 4'(PRE_ONES);
    localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);
    localparam logic [8:0] LAST_FRM = 9'(NUM_FRAMES);

    state_t                state_q;
    logic [3:0]            ones_q;
    logic [7:0]            cnt_q;
    logic [8:0]            frame_q;
    logic [FRAME_BITS-1:0] shift_q;

    logic [FRAME_BITS:0]   shift_d;
    logic [8:0]            frame_d;

    // Widened concatenation keeps the shift legal even when FRAME_BITS is 1.
    assign shift_d = {shift_q, DIN};
    assign frame_d = frame_q + 9'd1;

    always_ff @(posedge K) begin
        if (R) begin
            state_q     <= S_IDLE;
            ones_q      <= '0;
            cnt_q       <= '0;
            frame_q     <= '0;
            shift_q     <= '0;
            FRAME_DATA  <= '0;
            FRAME_ADDR  <= '0;
            FRAME_VALID <= 1'b0;
            LENGTH      <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;
            if (DIN_VALID) begin
                case (state_q)
                    S_IDLE: begin
                        if (DIN) begin
                            if (ones_q != PRE_MAX) ones_q <= ones_q + 4'd1;
                        end else if (ones_q == PRE_MAX) begin
                            state_q <= S_START;
                            BUSY    <= 1'b1;
                            cnt_q   <= '0;
                            ones_q  <= '0;
                        end else begin
                            ones_q <= '0;
                        end
                    end
                    // Remaining start-code bits are 0,1,0: only the middle one is high.
                    S_START: begin
                        if (DIN != (cnt_q == 8'd1)) begin
                            state_q <= S_ERROR;
                            ERR     <= 1'b1;
                            BUSY    <= 1'b0;
                        end else if (cnt_q == 8'd2) begin
                            state_q <= S_LEN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_LEN: begin
                        LENGTH <= {LENGTH[22:0], DIN};
                        if (cnt_q == 8'd23) begin
                            state_q <= S_LTRAIL;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_LTRAIL: begin
                        if (!DIN) begin
                            state_q <= S_ERROR;
                            ERR     <= 1'b1;
                            BUSY    <= 1'b0;
                        end else if (cnt_q == 8'd3) begin
                            state_q <= S_FSTART;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_FSTART: begin
                        if (DIN) begin
                            state_q <= S_ERROR;
                            ERR     <= 1'b1;
                            BUSY    <= 1'b0;
                        end else begin
                            state_q <= S_FDATA;
                            cnt_q   <= '0;
                        end
                    end
                    S_FDATA: begin
                        shift_q <= shift_d[FRAME_BITS-1:0];
                        if (cnt_q == LAST_BIT) begin
                            state_q <= S_FSTOP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    // Frame is published only once all three stop bits have checked out.
                    S_FSTOP: begin
                        if (!DIN) begin
                            state_q <= S_ERROR;
                            ERR     <= 1'b1;
                            BUSY    <= 1'b0;
                        end else if (cnt_q == 8'd2) begin
                            FRAME_DATA  <= shift_q;
                            FRAME_ADDR  <= frame_q[7:0];
                            FRAME_VALID <= 1'b1;
                            frame_q     <= frame_d;
                            cnt_q       <= '0;
                            if (frame_d == LAST_FRM) begin
                                state_q <= S_DONE;
                                DONE    <= 1'b1;
                                BUSY    <= 1'b0;
                            end else begin
                                state_q <= S_FSTART;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Bench for xc20xx_cfg_loader: directed vector table, reset/corner sequences,
// and randomized streams scored against a bitstream-parsing reference model.
module tb_xc20xx_cfg_loader;

    localparam int FB = 4;
    localparam int NF = 2;
    localparam int PO = 8;

    logic          K = 1'b0;
    logic          R = 1'b1;
    logic          DIN = 1'b0;
    logic          DIN_VALID = 1'b0;
    logic [FB-1:0] FRAME_DATA;
    logic [7:0]    FRAME_ADDR;
    logic          FRAME_VALID;
    logic [23:0]   LENGTH;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    xc20xx_cfg_loader #(
        .FRAME_BITS(FB),
        .NUM_FRAMES(NF),
        .PRE_ONES  (PO)
    ) dut (
        .K          (K),
        .R          (R),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .FRAME_DATA (FRAME_DATA),
        .FRAME_ADDR (FRAME_ADDR),
        .FRAME_VALID(FRAME_VALID),
        .LENGTH     (LENGTH),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 K = ~K;

    int checks = 0;
    int errors = 0;

    bit          stim[$];
    logic [11:0] got[$];
    logic [11:0] m_fr[$];
    logic [23:0] m_len;
    bit          m_done, m_err, m_busy;

    bit          fv_long, hold_bad, prev_fv, r_seen;
    logic [11:0] prev_fd;

    typedef struct {
        int          kind;
        int          gap;
        logic [23:0] blen;
        logic [3:0]  d0;
        logic [3:0]  d1;
        int          nfr;
        logic [23:0] elen;
        bit          done;
        bit          err;
    } vec_t;

    vec_t vt[6];

    // Output monitor: collects emitted frames, watches pulse width and output hold.
    always @(posedge K) r_seen <= R;
    always @(negedge K) begin
        if (FRAME_VALID) got.push_back({FRAME_ADDR, FRAME_DATA});
        if (FRAME_VALID && prev_fv) fv_long = 1'b1;
        if (!r_seen && !FRAME_VALID && ({FRAME_ADDR, FRAME_DATA} != prev_fd)) hold_bad = 1'b1;
        prev_fv = FRAME_VALID;
        prev_fd = {FRAME_ADDR, FRAME_DATA};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        R = 1'b1;
        DIN_VALID = 1'b0;
        DIN = 1'b0;
        repeat (2) @(posedge K);
        #1 R = 1'b0;
        @(negedge K);
        #1;
        got.delete();
        fv_long = 1'b0;
        hold_bad = 1'b0;
    endtask

    task automatic build(input logic [23:0] len, input logic [3:0] d0, input logic [3:0] d1);
        logic [3:0] d;
        stim.delete();
        repeat (PO) stim.push_back(1'b1);
        stim.push_back(1'b0); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
        for (int i = 23; i >= 0; i--) stim.push_back(len[i]);
        repeat (4) stim.push_back(1'b1);
        for (int f = 0; f < NF; f++) begin
            d = (f == 0) ? d0 : d1;
            stim.push_back(1'b0);
            for (int i = FB - 1; i >= 0; i--) stim.push_back(d[i]);
            repeat (3) stim.push_back(1'b1);
        end
    endtask

    // gap: 0 = continuous, 1 = DIN_VALID alternates 0/1, 2 = random idle cycles.
    task automatic drive_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                DIN_VALID = 1'b0;
                DIN = 1'($urandom);
                @(posedge K);
                #1;
            end
            DIN = stim[i];
            DIN_VALID = 1'b1;
            @(posedge K);
            #1;
        end
        DIN_VALID = 1'b0;
    endtask

    task automatic flush();
        repeat (3) @(posedge K);
        #1;
    endtask

    // Reference: walk the consumed bit sequence through the loader's framing rules.
    task automatic model_run();
        int         p;
        int         ones;
        logic [3:0] d;
        m_fr.delete();
        m_len = '0;
        m_done = 1'b0;
        m_err = 1'b0;
        m_busy = 1'b0;
        p = 0;
        ones = 0;
        while (1) begin
            if (p >= stim.size()) return;
            if (stim[p]) ones++;
            else if (ones >= PO) begin
                p++;
                break;
            end else ones = 0;
            p++;
        end
        m_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (p >= stim.size()) return;
            if (stim[p] != (i == 1)) begin m_err = 1'b1; m_busy = 1'b0; return; end
            p++;
        end
        for (int i = 0; i < 24; i++) begin
            if (p >= stim.size()) return;
            m_len = {m_len[22:0], stim[p]};
            p++;
        end
        for (int i = 0; i < 4; i++) begin
            if (p >= stim.size()) return;
            if (!stim[p]) begin m_err = 1'b1; m_busy = 1'b0; return; end
            p++;
        end
        for (int f = 0; f < NF; f++) begin
            if (p >= stim.size()) return;
            if (stim[p]) begin m_err = 1'b1; m_busy = 1'b0; return; end
            p++;
            d = '0;
            for (int i = 0; i < FB; i++) begin
                if (p >= stim.size()) return;
                d = {d[2:0], stim[p]};
                p++;
            end
            for (int i = 0; i < 3; i++) begin
                if (p >= stim.size()) return;
                if (!stim[p]) begin m_err = 1'b1; m_busy = 1'b0; return; end
                p++;
            end
            m_fr.push_back({8'(f), d});
        end
        m_done = 1'b1;
        m_busy = 1'b0;
    endtask

    task automatic check_run(input string tag);
        chk({tag, ".nframes"}, 64'(got.size()), 64'(m_fr.size()));
        for (int i = 0; i < m_fr.size() && i < got.size(); i++)
            chk($sformatf("%s.frame%0d", tag, i), 64'(got[i]), 64'(m_fr[i]));
        chk({tag, ".LENGTH"}, 64'(LENGTH), 64'(m_len));
        chk({tag, ".DONE"}, 64'(DONE), 64'(m_done));
        chk({tag, ".ERR"}, 64'(ERR), 64'(m_err));
        chk({tag, ".BUSY"}, 64'(BUSY), 64'(m_busy));
        chk({tag, ".fv_one_cycle"}, 64'(fv_long), 64'(0));
        chk({tag, ".data_hold"}, 64'(hold_bad), 64'(0));
    endtask

    initial begin
        vt[0] = '{0, 0, 24'h000010, 4'hA, 4'h6, 2, 24'h000010, 1'b1, 1'b0};
        vt[1] = '{0, 1, 24'h000010, 4'hA, 4'h6, 2, 24'h000010, 1'b1, 1'b0};
        vt[2] = '{1, 0, 24'h000010, 4'hA, 4'h6, 2, 24'h000010, 1'b1, 1'b0};
        vt[3] = '{2, 0, 24'h000010, 4'hA, 4'h6, 1, 24'h000010, 1'b0, 1'b1};
        vt[4] = '{3, 0, 24'h000010, 4'hA, 4'h6, 0, 24'h000000, 1'b0, 1'b1};
        vt[5] = '{0, 2, 24'hABCDEF, 4'hF, 4'h0, 2, 24'hABCDEF, 1'b1, 1'b0};

        do_reset();
        chk("reset_outputs",
            64'({FRAME_DATA, FRAME_ADDR, FRAME_VALID, LENGTH, BUSY, DONE, ERR}), 64'(0));

        foreach (vt[v]) begin
            do_reset();
            build(vt[v].blen, vt[v].d0, vt[v].d1);
            case (vt[v].kind)
                1: begin
                    stim.push_front(1'b0);
                    repeat (5) stim.push_front(1'b1);
                end
                2: stim[54] = 1'b0;
                3: begin
                    stim.push_front(1'b0); stim.push_front(1'b1);
                    stim.push_front(1'b1); stim.push_front(1'b0);
                    repeat (PO) stim.push_front(1'b1);
                end
                default: ;
            endcase
            drive_range(0, stim.size(), vt[v].gap);
            flush();
            m_fr.delete();
            if (vt[v].nfr > 0) m_fr.push_back({8'd0, vt[v].d0});
            if (vt[v].nfr > 1) m_fr.push_back({8'd1, vt[v].d1});
            m_len = vt[v].elen;
            m_done = vt[v].done;
            m_err = vt[v].err;
            m_busy = 1'b0;
            check_run($sformatf("vec%0d", v));
        end

        // BUSY rises with the first start-code bit; then reset in the middle of frame 1 data.
        do_reset();
        build(24'h000010, 4'hA, 4'h6);
        drive_range(0, PO + 1, 0);
        chk("busy_after_start_bit", 64'({BUSY, ERR, DONE}), 64'(3'b100));
        drive_range(PO + 1, 51, 0);
        chk("midstream_frames_before_reset", 64'(got.size()), 64'(1));
        R = 1'b1;
        DIN_VALID = 1'b1;
        DIN = 1'b1;
        @(posedge K);
        #1;
        R = 1'b0;
        DIN_VALID = 1'b0;
        chk("midstream_reset_outputs",
            64'({FRAME_DATA, FRAME_ADDR, FRAME_VALID, LENGTH, BUSY, DONE, ERR}), 64'(0));
        drive_range(51, stim.size(), 0);
        flush();
        chk("no_frame_after_reset_from_partial", 64'(got.size()), 64'(1));
        got.delete();
        drive_range(0, stim.size(), 0);
        flush();
        m_fr.delete();
        m_fr.push_back({8'd0, 4'hA});
        m_fr.push_back({8'd1, 4'h6});
        m_len = 24'h000010;
        m_done = 1'b1;
        m_err = 1'b0;
        m_busy = 1'b0;
        check_run("replay");

        // Randomized streams against the reference model.
        for (int it = 0; it < 40; it++) begin
            int n;
            do_reset();
            build(24'($urandom), 4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 4)) stim.push_front(1'b1);
            if ($urandom_range(0, 2) == 0) begin
                stim.push_front(1'b0);
                repeat ($urandom_range(0, 9)) stim.push_front(1'b1);
            end
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(0, stim.size() - 1));
                stim[n] = !stim[n];
            end
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 10)) void'(stim.pop_back());
                1: repeat ($urandom_range(1, 10)) stim.push_back(1'($urandom));
                default: ;
            endcase
            model_run();
            drive_range(0, stim.size(), int'($urandom_range(0, 2)));
            flush();
            check_run($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
